// File: rtl/udma_sdio_cmdq_reg_if.sv
// SDIO configuration register block: staged command queue with issue FSM,
// response/status capture, sticky W1C interrupt status and clock-divider handshake.
module udma_sdio_cmdq_reg_if #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [31:0]              cfg_data_i,
    input  logic [4:0]               cfg_addr_i,
    input  logic                     cfg_valid_i,
    input  logic                     cfg_rwn_i,
    output logic [31:0]              cfg_data_o,
    output logic                     cfg_ready_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [5:0]               cmd_op_o,
    output logic [31:0]              cmd_arg_o,
    output logic [2:0]               cmd_rsp_type_o,
    output logic                     data_en_o,
    output logic                     data_rwn_o,
    output logic                     data_quad_o,
    output logic [9:0]               data_block_size_o,
    output logic [7:0]               data_block_num_o,
    input  logic                     txrx_eot_i,
    input  logic                     txrx_err_i,
    input  logic [15:0]              txrx_status_i,
    input  logic [RSP_WORDS*32-1:0]  rsp_data_i,
    output logic [7:0]               clk_div_data_o,
    output logic                     clk_div_valid_o,
    input  logic                     clk_div_ack_i,
    output logic                     irq_o
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] arg;
        logic [2:0]  rsp_type;
        logic        en;
        logic        rwn;
        logic        quad;
        logic [9:0]  block_size;
        logic [7:0]  block_num;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    cmd_t          stage_q;
    cmd_t          queue_q [CMD_DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [4:0]    count_rd;
    logic [31:0]   rsp_word_q [RSP_WORDS];
    logic [15:0]   status_q;
    logic          eot_q, err_q, ovf_q;
    logic [2:0]    irq_en_q;
    logic          irq_q;
    logic [7:0]    div_data_q;
    logic          div_valid_q;

    logic wr, full, empty, push_req, push_ok, pop, flush;
    logic sts_wr;

    assign wr       = cfg_valid_i & ~cfg_rwn_i;
    assign full     = (count_q == CW'(CMD_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = wr && (cfg_addr_i == 5'h03) && cfg_data_i[0];
    // An error during the data phase discards everything still queued behind it.
    assign flush    = (wr && (cfg_addr_i == 5'h03) && cfg_data_i[1]) ||
                      ((state_q == WAIT) && txrx_err_i);
    assign push_ok  = push_req & ~full & ~flush;
    assign pop      = (state_q == ISSUE) & cmd_ready_i & ~flush;
    assign sts_wr   = wr && (cfg_addr_i == 5'h11);
    assign count_rd = 5'(count_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stage_q  <= '0;
            irq_en_q <= '0;
        end else if (wr) begin
            case (cfg_addr_i)
                5'h00: begin
                    stage_q.op       <= cfg_data_i[13:8];
                    stage_q.rsp_type <= cfg_data_i[2:0];
                end
                5'h01: stage_q.arg <= cfg_data_i;
                5'h02: begin
                    stage_q.en         <= cfg_data_i[0];
                    stage_q.rwn        <= cfg_data_i[1];
                    stage_q.quad       <= cfg_data_i[2];
                    stage_q.block_num  <= cfg_data_i[15:8];
                    stage_q.block_size <= cfg_data_i[25:16];
                end
                5'h12:   irq_en_q <= cfg_data_i[2:0];
                default: ;
            endcase
        end
    end

    // NOTE: queue storage is reset too, so the head never presents X before the first push.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < CMD_DEPTH; i++) queue_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                queue_q[wr_ptr_q] <= stage_q;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: state_d gets its default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty && !flush) state_d = ISSUE;
            ISSUE:   if (flush) state_d = IDLE;
                     else if (cmd_ready_i) state_d = WAIT;
            WAIT:    if (txrx_eot_i || txrx_err_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_valid_o       = (state_q == ISSUE);
    assign head              = cmd_valid_o ? queue_q[rd_ptr_q] : '0;
    assign cmd_op_o          = head.op;
    assign cmd_arg_o         = head.arg;
    assign cmd_rsp_type_o    = head.rsp_type;
    assign data_en_o         = head.en;
    assign data_rwn_o        = head.rwn;
    assign data_quad_o       = head.quad;
    assign data_block_size_o = head.block_size;
    assign data_block_num_o  = head.block_num;

    // Set events take priority over a W1C clear landing in the same cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < RSP_WORDS; i++) rsp_word_q[i] <= '0;
            status_q <= '0;
            eot_q    <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (txrx_eot_i || txrx_err_i) status_q <= txrx_status_i;
            if (txrx_eot_i)
                for (int i = 0; i < RSP_WORDS; i++) rsp_word_q[i] <= rsp_data_i[i*32 +: 32];
            eot_q <= txrx_eot_i | (eot_q & ~(sts_wr & cfg_data_i[0]));
            err_q <= txrx_err_i | (err_q & ~(sts_wr & cfg_data_i[1]));
            ovf_q <= (push_req & full) | (ovf_q & ~(sts_wr & cfg_data_i[2]));
            irq_q <= |({ovf_q, err_q, eot_q} & irq_en_q);
        end
    end

    // Divider writes while a request is outstanding are dropped, data included.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_data_q  <= '0;
            div_valid_q <= 1'b0;
        end else if (wr && (cfg_addr_i == 5'h10) && !div_valid_q) begin
            div_data_q  <= cfg_data_i[7:0];
            div_valid_q <= cfg_data_i[8];
        end else if (clk_div_ack_i) begin
            div_valid_q <= 1'b0;
        end
    end

    assign clk_div_data_o  = div_data_q;
    assign clk_div_valid_o = div_valid_q;
    assign irq_o           = irq_q;
    assign cfg_ready_o     = 1'b1;

    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            5'h00: cfg_data_o = {18'b0, stage_q.op, 5'b0, stage_q.rsp_type};
            5'h01: cfg_data_o = stage_q.arg;
            5'h02: cfg_data_o = {6'b0, stage_q.block_size, stage_q.block_num, 5'b0,
                                 stage_q.quad, stage_q.rwn, stage_q.en};
            5'h03: cfg_data_o = {11'b0, count_rd, 14'b0, full, empty};
            5'h10: cfg_data_o = {23'b0, div_valid_q, div_data_q};
            5'h11: cfg_data_o = {status_q, 13'b0, ovf_q, err_q, eot_q};
            5'h12: cfg_data_o = {29'b0, irq_en_q};
            default: begin
                for (int i = 0; i < RSP_WORDS; i++)
                    if (cfg_addr_i == 5'(4 + i)) cfg_data_o = rsp_word_q[i];
            end
        endcase
    end
endmodule

// File: tb/tb_udma_sdio_cmdq_reg_if.sv
// Directed bench for udma_sdio_cmdq_reg_if: register vector table plus
// hand-written sequences for queue, issue FSM, capture, irq and divider behaviour.
module tb_udma_sdio_cmdq_reg_if;
    localparam int CMD_DEPTH = 4;
    localparam int RSP_WORDS = 4;
    localparam int NV        = 15;

    logic                    clk_i = 1'b0;
    logic                    rstn_i = 1'b0;
    logic [31:0]             cfg_data_i = '0;
    logic [4:0]              cfg_addr_i = '0;
    logic                    cfg_valid_i = 1'b0;
    logic                    cfg_rwn_i = 1'b1;
    logic [31:0]             cfg_data_o;
    logic                    cfg_ready_o;
    logic                    cmd_valid_o;
    logic                    cmd_ready_i = 1'b0;
    logic [5:0]              cmd_op_o;
    logic [31:0]             cmd_arg_o;
    logic [2:0]              cmd_rsp_type_o;
    logic                    data_en_o, data_rwn_o, data_quad_o;
    logic [9:0]              data_block_size_o;
    logic [7:0]              data_block_num_o;
    logic                    txrx_eot_i = 1'b0;
    logic                    txrx_err_i = 1'b0;
    logic [15:0]             txrx_status_i = '0;
    logic [RSP_WORDS*32-1:0] rsp_data_i = '0;
    logic [7:0]              clk_div_data_o;
    logic                    clk_div_valid_o;
    logic                    clk_div_ack_i = 1'b0;
    logic                    irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    udma_sdio_cmdq_reg_if #(.CMD_DEPTH(CMD_DEPTH), .RSP_WORDS(RSP_WORDS)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
        .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_op_o(cmd_op_o),
        .cmd_arg_o(cmd_arg_o), .cmd_rsp_type_o(cmd_rsp_type_o),
        .data_en_o(data_en_o), .data_rwn_o(data_rwn_o), .data_quad_o(data_quad_o),
        .data_block_size_o(data_block_size_o), .data_block_num_o(data_block_num_o),
        .txrx_eot_i(txrx_eot_i), .txrx_err_i(txrx_err_i), .txrx_status_i(txrx_status_i),
        .rsp_data_i(rsp_data_i), .clk_div_data_o(clk_div_data_o),
        .clk_div_valid_o(clk_div_valid_o), .clk_div_ack_i(clk_div_ack_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        do_wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        tick(1);
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b1;
        cfg_data_i  = '0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = a;
        #1;
        check(name, cfg_data_o, exp);
        cfg_valid_i = 1'b0;
    endtask

    task automatic accept_cmd();
        cmd_ready_i = 1'b1;
        tick(1);
        cmd_ready_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'h00, 32'hFFFF_FFFF, 5'h00, 32'h0000_3F07};
        vecs[1]  = '{1'b1, 5'h00, 32'h0000_1101, 5'h00, 32'h0000_1101};
        vecs[2]  = '{1'b1, 5'h01, 32'hDEAD_BEEF, 5'h01, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 5'h02, 32'hFFFF_FFFF, 5'h02, 32'h03FF_FF07};
        vecs[4]  = '{1'b1, 5'h02, 32'hFD55_34FD, 5'h02, 32'h0155_3405};
        vecs[5]  = '{1'b1, 5'h12, 32'hFFFF_FFFF, 5'h12, 32'h0000_0007};
        vecs[6]  = '{1'b1, 5'h12, 32'h0000_0005, 5'h12, 32'h0000_0005};
        vecs[7]  = '{1'b1, 5'h13, 32'h1234_5678, 5'h13, 32'h0000_0000};
        vecs[8]  = '{1'b1, 5'h1F, 32'hFFFF_FFFF, 5'h1F, 32'h0000_0000};
        vecs[9]  = '{1'b0, 5'h00, 32'h0000_0000, 5'h08, 32'h0000_0000};
        vecs[10] = '{1'b0, 5'h00, 32'h0000_0000, 5'h0F, 32'h0000_0000};
        vecs[11] = '{1'b1, 5'h11, 32'hFFFF_FFFF, 5'h11, 32'h0000_0000};
        vecs[12] = '{1'b1, 5'h02, 32'h0000_0000, 5'h02, 32'h0000_0000};
        vecs[13] = '{1'b1, 5'h12, 32'h0000_0000, 5'h12, 32'h0000_0000};
        vecs[14] = '{1'b0, 5'h00, 32'h0000_0000, 5'h03, 32'h0000_0001};

        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        tick(1);

        // Reset state
        check("rst_cfg_ready", 32'(cfg_ready_o), 32'h1);
        check("rst_cmd_valid", 32'(cmd_valid_o), 32'h0);
        check("rst_cmd_arg", cmd_arg_o, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_div", {23'b0, clk_div_valid_o, clk_div_data_o}, 32'h0);
        for (int a = 0; a < 32; a++)
            rd_check($sformatf("rst_reg_%02h", a), 5'(a), (a == 3) ? 32'h1 : 32'h0);
        tick(1);

        // Register table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].do_wr) wr_reg(vecs[i].waddr, vecs[i].wdata);
            rd_check($sformatf("reg_vec%0d", i), vecs[i].raddr, vecs[i].exp);
            if (!vecs[i].do_wr) tick(1);
        end

        // Single command issue, latency and pop
        wr_reg(5'h00, 32'h0000_1101);
        wr_reg(5'h01, 32'h0000_0200);
        wr_reg(5'h03, 32'h1);
        check("issue_lat_idle", 32'(cmd_valid_o), 32'h0);
        rd_check("cnt_after_push", 5'h03, 32'h0001_0000);
        tick(1);
        check("issue_valid", 32'(cmd_valid_o), 32'h1);
        check("issue_op", 32'(cmd_op_o), 32'h11);
        check("issue_arg", cmd_arg_o, 32'h0000_0200);
        check("issue_rsp", 32'(cmd_rsp_type_o), 32'h1);
        tick(2);
        check("issue_hold_valid", 32'(cmd_valid_o), 32'h1);
        check("issue_hold_op", 32'(cmd_op_o), 32'h11);
        accept_cmd();
        check("wait_valid", 32'(cmd_valid_o), 32'h0);
        check("wait_op_zero", 32'(cmd_op_o), 32'h0);
        check("wait_arg_zero", cmd_arg_o, 32'h0);
        rd_check("empty_after_pop", 5'h03, 32'h1);

        // Second command queued while the first is in flight; eot capture and spacing
        wr_reg(5'h00, 32'h0000_2203);
        wr_reg(5'h02, 32'h0008_0105);
        wr_reg(5'h03, 32'h1);
        tick(2);
        check("wait_holds", 32'(cmd_valid_o), 32'h0);
        txrx_eot_i    = 1'b1;
        txrx_status_i = 16'h1234;
        rsp_data_i    = {32'h4, 32'h3, 32'h2, 32'h1};
        tick(1);
        txrx_eot_i    = 1'b0;
        txrx_status_i = '0;
        rsp_data_i    = '0;
        check("eot_gap_idle", 32'(cmd_valid_o), 32'h0);
        rd_check("rsp_w0", 5'h04, 32'h1);
        rd_check("rsp_w1", 5'h05, 32'h2);
        rd_check("rsp_w2", 5'h06, 32'h3);
        rd_check("rsp_w3", 5'h07, 32'h4);
        tick(1);
        check("eot_gap_issue", 32'(cmd_valid_o), 32'h1);
        check("cmd2_op", 32'(cmd_op_o), 32'h22);
        check("cmd2_rsp", 32'(cmd_rsp_type_o), 32'h3);
        check("cmd2_data", {29'b0, data_quad_o, data_rwn_o, data_en_o}, 32'h5);
        check("cmd2_bnum", 32'(data_block_num_o), 32'h1);
        check("cmd2_bsize", 32'(data_block_size_o), 32'h8);
        accept_cmd();
        txrx_eot_i    = 1'b1;
        txrx_status_i = 16'h1234;
        tick(1);
        txrx_eot_i    = 1'b0;
        txrx_status_i = '0;
        rd_check("sts_eot", 5'h11, 32'h1234_0001);
        wr_reg(5'h11, 32'h1);
        rd_check("sts_eot_clr", 5'h11, 32'h1234_0000);

        // Overflow with ovf interrupt enabled, then flush while issuing
        wr_reg(5'h12, 32'h4);
        wr_reg(5'h00, 32'h0000_3300);
        for (int i = 0; i < 5; i++) wr_reg(5'h03, 32'h1);
        check("ovf_irq_delay", 32'(irq_o), 32'h0);
        rd_check("ovf_count_full", 5'h03, 32'h0004_0002);
        rd_check("ovf_sticky", 5'h11, 32'h1234_0004);
        check("ovf_head_op", 32'(cmd_op_o), 32'h33);
        tick(1);
        check("ovf_irq", 32'(irq_o), 32'h1);
        wr_reg(5'h11, 32'h4);
        rd_check("ovf_clr", 5'h11, 32'h1234_0000);
        tick(1);
        check("ovf_irq_clr", 32'(irq_o), 32'h0);
        wr_reg(5'h03, 32'h2);
        check("flush_issue_valid", 32'(cmd_valid_o), 32'h0);
        check("flush_issue_op", 32'(cmd_op_o), 32'h0);
        rd_check("flush_empty", 5'h03, 32'h1);
        tick(2);
        check("flush_stays_idle", 32'(cmd_valid_o), 32'h0);
        wr_reg(5'h12, 32'h0);

        // Error during data phase flushes the remaining queue
        wr_reg(5'h00, 32'h0000_0100);
        wr_reg(5'h03, 32'h1);
        wr_reg(5'h00, 32'h0000_0200);
        wr_reg(5'h03, 32'h1);
        wr_reg(5'h00, 32'h0000_0300);
        wr_reg(5'h03, 32'h1);
        check("err_head_op", 32'(cmd_op_o), 32'h1);
        rd_check("err_count3", 5'h03, 32'h0003_0000);
        accept_cmd();
        rd_check("err_count2", 5'h03, 32'h0002_0000);
        txrx_err_i    = 1'b1;
        txrx_status_i = 16'hBEEF;
        tick(1);
        txrx_err_i    = 1'b0;
        txrx_status_i = '0;
        check("err_valid", 32'(cmd_valid_o), 32'h0);
        rd_check("err_flushed", 5'h03, 32'h1);
        rd_check("err_status", 5'h11, 32'hBEEF_0002);
        tick(2);
        check("err_idle", 32'(cmd_valid_o), 32'h0);
        wr_reg(5'h11, 32'h2);
        rd_check("err_clr", 5'h11, 32'hBEEF_0000);

        // Set beats simultaneous clear; eot+err in one cycle
        txrx_eot_i    = 1'b1;
        txrx_status_i = 16'h5555;
        wr_reg(5'h11, 32'h1);
        txrx_eot_i    = 1'b0;
        txrx_status_i = '0;
        rd_check("eot_set_wins", 5'h11, 32'h5555_0001);
        wr_reg(5'h11, 32'h1);
        rd_check("eot_w1c", 5'h11, 32'h5555_0000);
        txrx_eot_i    = 1'b1;
        txrx_err_i    = 1'b1;
        txrx_status_i = 16'h7777;
        tick(1);
        txrx_eot_i    = 1'b0;
        txrx_err_i    = 1'b0;
        txrx_status_i = '0;
        rd_check("eot_err_both", 5'h11, 32'h7777_0003);
        wr_reg(5'h11, 32'h3);
        rd_check("both_clr", 5'h11, 32'h7777_0000);

        // Clock divider handshake
        wr_reg(5'h10, 32'h105);
        check("div_valid", 32'(clk_div_valid_o), 32'h1);
        check("div_data", 32'(clk_div_data_o), 32'h05);
        rd_check("div_busy", 5'h10, 32'h105);
        wr_reg(5'h10, 32'h1FF);
        check("div_busy_ignored", 32'(clk_div_data_o), 32'h05);
        rd_check("div_busy_rd", 5'h10, 32'h105);
        clk_div_ack_i = 1'b1;
        tick(1);
        clk_div_ack_i = 1'b0;
        check("div_acked", 32'(clk_div_valid_o), 32'h0);
        rd_check("div_done_rd", 5'h10, 32'h05);
        clk_div_ack_i = 1'b1;
        tick(1);
        clk_div_ack_i = 1'b0;
        rd_check("div_stray_ack", 5'h10, 32'h05);

        // Asynchronous reset in WAIT with two entries queued
        wr_reg(5'h12, 32'h1);
        txrx_eot_i = 1'b1;
        tick(1);
        txrx_eot_i = 1'b0;
        wr_reg(5'h10, 32'h1AA);
        wr_reg(5'h00, 32'h0000_0A00);
        for (int i = 0; i < 3; i++) wr_reg(5'h03, 32'h1);
        accept_cmd();
        rd_check("pre_rst_count", 5'h03, 32'h0002_0000);
        check("pre_rst_irq", 32'(irq_o), 32'h1);
        check("pre_rst_div", 32'(clk_div_valid_o), 32'h1);
        rstn_i = 1'b0;
        #2;
        check("arst_valid", 32'(cmd_valid_o), 32'h0);
        check("arst_cmd", {cmd_op_o, cmd_rsp_type_o, data_en_o, data_rwn_o, data_quad_o,
                           data_block_size_o, data_block_num_o}, 32'h0);
        check("arst_irq", 32'(irq_o), 32'h0);
        check("arst_div", {23'b0, clk_div_valid_o, clk_div_data_o}, 32'h0);
        check("arst_ready", 32'(cfg_ready_o), 32'h1);
        rd_check("arst_count", 5'h03, 32'h1);
        rd_check("arst_sts", 5'h11, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick(3);
        check("post_rst_idle", 32'(cmd_valid_o), 32'h0);
        rd_check("post_rst_stage", 5'h00, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
